fp32_mant_mul_seq: RTL and testbench
====================================

Name: fp32_mant_mul_seq

Overview:
Sequential mantissa multiplier for the FP32 FPU multiply path. It sits directly upstream of the 4x4 nibble multiplier. Each cycle it drives one nibble pair to that multiplier, takes back the 8-bit partial product, and accumulates it with the correct shift into a 2*WIDTH-bit result. The result is handed to the normalise/round stage through a valid/ready handshake.

Parameters:
WIDTH, 24, operand width in bits (significand with hidden 1); must be a multiple of 4 and at least 8
NIB, WIDTH/4, nibbles per operand (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  WIDTH  multiplicand mantissa
in_b  input  WIDTH  multiplier mantissa
mul_a  output  4  nibble to 4x4 multiplier input A
mul_b  output  4  nibble to 4x4 multiplier input B
mul_p  input  8  product from 4x4 multiplier (combinational from mul_a/mul_b, same cycle)
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
out_prod  output  2*WIDTH  unsigned product in_a*in_b
busy  output  1  high in RUN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_prod=0, busy=0, mul_a=mul_b=0, i=j=0, acc=0, a_reg=b_reg=0. Reset mid-RUN or mid-DONE aborts the operation; no output is produced.
- States: IDLE, RUN, DONE.
- in_ready=1 only in IDLE.
- IDLE:
  - Accept on in_valid&&in_ready: latch a_reg=in_a, b_reg=in_b, acc=0, i=0, j=0.
  - If in_a==0 or in_b==0, go to DONE with acc=0 (zero shortcut).
  - Otherwise go to RUN.
- RUN:
  - Outputs: mul_a=a_reg[4i+3:4i], mul_b=b_reg[4j+3:4j].
  - Each cycle: acc <= acc + (zero-extended mul_p << 4*(i+j)). Accumulation is 2*WIDTH bits wide; overflow is impossible.
  - Index order: j increments; on j==NIB-1, j wraps to 0 and i increments.
  - When i==NIB-1 and j==NIB-1, the final add occurs and the state goes to DONE.
  - RUN lasts exactly NIB*NIB cycles (36 at the default).
- DONE:
  - Outputs: out_valid=1, out_prod=acc. Both are held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. in_ready rises the next cycle; a new accept cannot occur in the same cycle as the handoff.
- Outside RUN: mul_a=mul_b=0.
- out_prod is registered; it is 0 in IDLE after reset and retains the last value otherwise. Only out_valid qualifies it.
- Latency (accept edge to first cycle with out_valid=1):
  - NIB*NIB+1 cycles for the normal path (37 at the default).
  - 1 cycle for a zero operand.
- Inputs in_a/in_b are ignored while in_ready=0. in_valid held high during RUN/DONE causes no effect.
- Throughput: one product per NIB*NIB+2 cycles with out_ready tied high.

Test Plan:
- WIDTH=24, in_a=24'hFFFFFF, in_b=24'hFFFFFF, out_ready=1 -> out_valid exactly 37 cycles after accept; out_prod=48'hFFFFFE000001; busy high for 36 cycles.
- WIDTH=24, in_a=24'h800000, in_b=24'hC00000 -> out_prod=48'h600000000000; mul_a/mul_b sequence matches nibble order (i outer, j inner) in every RUN cycle.
- Zero shortcut: in_a=0, in_b=24'hABCDEF -> out_valid the cycle after accept, out_prod=0, busy never asserts, mul_a=mul_b=0 throughout.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_prod and out_valid stable; in_ready=0 and new in_valid ignored; on out_ready=1 the handoff occurs once, and the next operand is accepted one cycle later.
- Reset mid-RUN: assert rst_n=0 at RUN cycle 20 -> all outputs immediately at reset values; after release, a new op 24'h000003*24'h000005 gives 48'h00000000000F.
- WIDTH=8: in_a=8'hFF, in_b=8'hFF -> 4 RUN cycles, out_prod=16'hFE01; random 1000-pair check against a behavioural model at WIDTH=24.

Source files
------------

// File: rtl/fp32_mant_mul_seq.sv
// Sequential mantissa multiplier: walks nibble pairs through an external
// 4x4 multiplier and accumulates shifted partial products.
module fp32_mant_mul_seq #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic [3:0]         mul_a,
   output logic [3:0]         mul_b,
   input  logic [7:0]         mul_p,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic               busy
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int PW  = 2 * WIDTH;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_i;
   logic [IW-1:0]    r_j;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_prod;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;
   logic [IW:0]      w_ij;
   logic [PW-1:0]    w_pp;
   logic [PW-1:0]    w_term;
   logic [PW-1:0]    w_sum;
   logic             w_last;
   logic             w_zero;

   // Nibble selection by shifting keeps the index arithmetic width-clean.
   assign w_a_sh = r_a >> {r_i, 2'b00};
   assign w_b_sh = r_b >> {r_j, 2'b00};
   assign w_ij   = {1'b0, r_i} + {1'b0, r_j};
   assign w_pp   = {{(PW-8){1'b0}}, mul_p};
   assign w_term = w_pp << {w_ij, 2'b00};
   assign w_sum  = r_acc + w_term;
   assign w_last = (r_i == LAST) && (r_j == LAST);
   assign w_zero = (in_a == '0) || (in_b == '0);

   assign mul_a     = r_busy ? w_a_sh[3:0] : 4'd0;
   assign mul_b     = r_busy ? w_b_sh[3:0] : 4'd0;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_prod  = r_prod;
   assign busy      = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_acc       <= '0;
         r_prod      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= in_a;
                  r_b        <= in_b;
                  r_acc      <= '0;
                  r_i        <= '0;
                  r_j        <= '0;
                  r_in_ready <= 1'b0;
                  // A zero operand skips the nibble walk entirely.
                  if (w_zero) begin
                     r_prod      <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_acc <= w_sum;
               if (w_last) begin
                  r_prod      <= w_sum;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_j == LAST) begin
                  r_j <= '0;
                  r_i <= r_i + IW'(1);
               end else begin
                  r_j <= r_j + IW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_mant_mul_seq.sv
// Directed and random checks of fp32_mant_mul_seq at WIDTH=24 and WIDTH=8,
// with a behavioural 4x4 nibble multiplier closing the loop.
module tb_fp32_mant_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_a;
   logic [23:0] in_b;
   logic [3:0]  mul_a;
   logic [3:0]  mul_b;
   logic [7:0]  mul_p;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] out_prod;
   logic        busy;

   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  in_a8;
   logic [7:0]  in_b8;
   logic [3:0]  mul_a8;
   logic [3:0]  mul_b8;
   logic [7:0]  mul_p8;
   logic        out_valid8;
   logic [15:0] out_prod8;
   logic        busy8;

   int nvec  = 0;
   int nfail = 0;

   assign mul_p  = mul_a * mul_b;
   assign mul_p8 = mul_a8 * mul_b8;

   fp32_mant_mul_seq #(.WIDTH(24)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .busy      (busy)
   );

   fp32_mant_mul_seq #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .in_a      (in_a8),
      .in_b      (in_b8),
      .mul_a     (mul_a8),
      .mul_b     (mul_b8),
      .mul_p     (mul_p8),
      .out_valid (out_valid8),
      .out_ready (1'b1),
      .out_prod  (out_prod8),
      .busy      (busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; accept happens at the following posedge.
   task automatic start(input logic [23:0] a, input logic [23:0] b);
      check("in_ready_idle", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = 24'($urandom);
      in_b     = 24'($urandom);
   endtask

   // Entered at the first negedge after accept; counts cycles to out_valid.
   task automatic wait_done(input logic [23:0] a, input logic [23:0] b,
                            output int lat, output int bcnt,
                            output bit seq_ok);
      logic [23:0] ta;
      logic [23:0] tb;
      lat    = 1;
      bcnt   = 0;
      seq_ok = 1'b1;
      while (!out_valid && lat < 200) begin
         if (busy) begin
            ta = a >> (4 * (bcnt / 6));
            tb = b >> (4 * (bcnt % 6));
            if (mul_a !== ta[3:0] || mul_b !== tb[3:0]) seq_ok = 1'b0;
            bcnt++;
         end else if (mul_a !== 4'd0 || mul_b !== 4'd0) begin
            seq_ok = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      if (mul_a !== 4'd0 || mul_b !== 4'd0 || busy !== 1'b0) seq_ok = 1'b0;
   endtask

   initial begin
      int          lat;
      int          bcnt;
      bit          ok;
      bit          stable;
      logic [47:0] hold;
      logic [23:0] ra;
      logic [23:0] rb;
      logic [47:0] re;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      in_valid8 = 1'b0;
      in_a8     = '0;
      in_b8     = '0;
      repeat (3) @(negedge clk);

      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_out_prod", {16'd0, out_prod}, 64'd0);
      check("rst_mul", {56'd0, mul_a, mul_b}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      start(24'hFFFFFF, 24'hFFFFFF);
      wait_done(24'hFFFFFF, 24'hFFFFFF, lat, bcnt, ok);
      check("ff_latency", 64'(lat), 64'd37);
      check("ff_busy_cycles", 64'(bcnt), 64'd36);
      check("ff_prod", {16'd0, out_prod}, 64'h0000FFFFFE000001);
      check("ff_seq", {63'd0, ok}, 64'd1);
      @(negedge clk);
      check("ff_handoff_valid", {63'd0, out_valid}, 64'd0);

      start(24'h800000, 24'hC00000);
      wait_done(24'h800000, 24'hC00000, lat, bcnt, ok);
      check("hi_latency", 64'(lat), 64'd37);
      check("hi_prod", {16'd0, out_prod}, 64'h0000600000000000);
      check("hi_seq", {63'd0, ok}, 64'd1);
      @(negedge clk);

      start(24'h000000, 24'hABCDEF);
      wait_done(24'h000000, 24'hABCDEF, lat, bcnt, ok);
      check("zero_latency", 64'(lat), 64'd1);
      check("zero_busy_cycles", 64'(bcnt), 64'd0);
      check("zero_prod", {16'd0, out_prod}, 64'd0);
      check("zero_mul_idle", {63'd0, ok}, 64'd1);
      @(negedge clk);

      out_ready = 1'b0;
      start(24'h001000, 24'h000011);
      wait_done(24'h001000, 24'h000011, lat, bcnt, ok);
      check("bp_latency", 64'(lat), 64'd37);
      check("bp_prod", {16'd0, out_prod}, 64'h0000000000011000);
      hold   = out_prod;
      stable = 1'b1;
      in_valid = 1'b1;
      in_a     = 24'h000007;
      in_b     = 24'h000009;
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_prod !== hold || in_ready !== 1'b0 ||
             busy !== 1'b0)
            stable = 1'b0;
      end
      check("bp_stable", {63'd0, stable}, 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_handoff_valid", {63'd0, out_valid}, 64'd0);
      check("bp_ready_after", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_next_accept", {62'd0, in_ready, busy}, 64'd1);
      wait_done(24'h000007, 24'h000009, lat, bcnt, ok);
      check("bp_next_latency", 64'(lat), 64'd37);
      check("bp_next_prod", {16'd0, out_prod}, 64'h000000000000003F);
      @(negedge clk);

      start(24'hFFFFFF, 24'hFFFFFF);
      repeat (19) @(negedge clk);
      check("mid_busy", {63'd0, busy}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("mid_rst_flags", {62'd0, out_valid, busy}, 64'd0);
      check("mid_rst_mul", {56'd0, mul_a, mul_b}, 64'd0);
      check("mid_rst_prod", {16'd0, out_prod}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start(24'h000003, 24'h000005);
      wait_done(24'h000003, 24'h000005, lat, bcnt, ok);
      check("post_rst_latency", 64'(lat), 64'd37);
      check("post_rst_prod", {16'd0, out_prod}, 64'h000000000000000F);
      @(negedge clk);

      check("w8_ready", {63'd0, in_ready8}, 64'd1);
      in_valid8 = 1'b1;
      in_a8     = 8'hFF;
      in_b8     = 8'hFF;
      @(negedge clk);
      in_valid8 = 1'b0;
      lat  = 1;
      bcnt = 0;
      while (!out_valid8 && lat < 50) begin
         if (busy8) bcnt++;
         @(negedge clk);
         lat++;
      end
      check("w8_latency", 64'(lat), 64'd5);
      check("w8_busy_cycles", 64'(bcnt), 64'd4);
      check("w8_prod", {48'd0, out_prod8}, 64'h000000000000FE01);
      @(negedge clk);

      for (int n = 0; n < 1000; n++) begin
         ra = 24'($urandom);
         rb = 24'($urandom);
         re = {24'd0, ra} * {24'd0, rb};
         start(ra, rb);
         wait_done(ra, rb, lat, bcnt, ok);
         check("rand_prod", {16'd0, out_prod}, {16'd0, re});
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
